// File: rtl/seg_scan_pkg.sv
// -----------------------------------------------------------------------------
// seg_scan_pkg
// Shared constants and types for the 7-segment scan receiver:
//   - common-line phase codes (LO / HI / BLANK)
//   - the 16 gfedcba segment patterns of the hex font
//   - FSM state and accepted-phase classification types
//   - sampled-bus width ({com, seg})
// -----------------------------------------------------------------------------
package seg_scan_pkg;

  // Common-line phase codes, active-high, com[3]=LSD, com[2]=MSD
  localparam logic [3:0] COM_LO    = 4'b1000;
  localparam logic [3:0] COM_HI    = 4'b0100;
  localparam logic [3:0] COM_BLANK = 4'b0000;

  // Hex font, bit order gfedcba (seg[0]=a .. seg[6]=g)
  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h7C;
  localparam logic [6:0] SEG_C = 7'h39;
  localparam logic [6:0] SEG_D = 7'h5E;
  localparam logic [6:0] SEG_E = 7'h79;
  localparam logic [6:0] SEG_F = 7'h71;

  // Width of the sampled bus {com[3:0], seg[6:0]}
  localparam int unsigned SMP_W = 11;

  typedef enum logic {
    HUNT    = 1'b0,
    HAVE_LO = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    PH_BLANK   = 2'd0,
    PH_LO      = 2'd1,
    PH_HI      = 2'd2,
    PH_ILLEGAL = 2'd3
  } phase_e;

endpackage

// File: rtl/seg_7_inv.sv
// -----------------------------------------------------------------------------
// seg_7_inv
// Combinational inverse of the hex 7-segment encoder.
// Ports:
//   seg [6:0] in  : segment pattern, gfedcba, active-high
//   hit       out : 1 when seg is one of the 16 font patterns
//   val [3:0] out : decoded hex value (0 when hit=0)
// -----------------------------------------------------------------------------
module seg_7_inv
  import seg_scan_pkg::*;
(
  input  logic [6:0] seg,
  output logic       hit,
  output logic [3:0] val
);

  // Table lookup; anything outside the font is a miss
  always_comb begin
    hit = 1'b1;
    val = 4'h0;
    case (seg)
      SEG_0:   val = 4'h0;
      SEG_1:   val = 4'h1;
      SEG_2:   val = 4'h2;
      SEG_3:   val = 4'h3;
      SEG_4:   val = 4'h4;
      SEG_5:   val = 4'h5;
      SEG_6:   val = 4'h6;
      SEG_7:   val = 4'h7;
      SEG_8:   val = 4'h8;
      SEG_9:   val = 4'h9;
      SEG_A:   val = 4'hA;
      SEG_B:   val = 4'hB;
      SEG_C:   val = 4'hC;
      SEG_D:   val = 4'hD;
      SEG_E:   val = 4'hE;
      SEG_F:   val = 4'hF;
      default: begin
        hit = 1'b0;
        val = 4'h0;
      end
    endcase
  end

endmodule

// File: rtl/seg_scan_rx.sv
// -----------------------------------------------------------------------------
// seg_scan_rx
// Receive-side decoder for a 2-digit multiplexed 7-segment bus. Synchronizes
// {com, seg}, waits for the sample to be stable, classifies each accepted
// phase and pairs an LSD with the following MSD.
// Ports:
//   clock            in  : system clock, rising edge
//   reset            in  : synchronous active-high reset
//   com [3:0]        in  : common lines (com[3]=LSD, com[2]=MSD, com[1:0]=0)
//   seg [6:0]        in  : segments, gfedcba, active-high
//   digit_lo [3:0]   out : last accepted LSD
//   digit_hi [3:0]   out : last accepted MSD
//   pair_valid       out : sticky, a complete pair was captured since reset
//   update           out : 1-cycle pulse, digit_lo/digit_hi loaded together
//   err              out : 1-cycle pulse, illegal com or seg accepted
//   err_count [7:0]  out : saturating count of err pulses
// -----------------------------------------------------------------------------
module seg_scan_rx
  import seg_scan_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] com,
  input  logic [6:0] seg,
  output logic [3:0] digit_lo,
  output logic [3:0] digit_hi,
  output logic       pair_valid,
  output logic       update,
  output logic       err,
  output logic [7:0] err_count
);

  // Counter thresholds: the accept fires on the increment from CNT_PRE to
  // CNT_ACC; the counter saturates at all-ones so it cannot re-fire while the
  // sample stays unchanged.
  localparam logic [CNT_W-1:0] CNT_ACC  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(STABLE_CYCLES - 2);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Input path and stability tracking
  logic [SMP_W-1:0] sync_q, sync_d;
  logic [SMP_W-1:0] smp_q, smp_d;
  logic [SMP_W-1:0] prev_q, prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             acc_q, acc_d;
  logic [SMP_W-1:0] acc_smp_q, acc_smp_d;

  // FSM and output state
  state_e     state_q, state_d;
  logic [3:0] lo_tmp_q, lo_tmp_d;
  logic [3:0] digit_lo_q, digit_lo_d;
  logic [3:0] digit_hi_q, digit_hi_d;
  logic       pair_valid_q, pair_valid_d;
  logic       update_q, update_d;
  logic       err_q, err_d;
  logic [7:0] err_count_q, err_count_d;

  // Classification of the accepted sample
  logic [3:0] acc_com_s;
  logic [6:0] acc_seg_s;
  logic       dec_hit_s;
  logic [3:0] dec_val_s;
  phase_e     phase_s;

  assign acc_com_s = acc_smp_q[10:7];
  assign acc_seg_s = acc_smp_q[6:0];

  seg_7_inv u_dec (
    .seg (acc_seg_s),
    .hit (dec_hit_s),
    .val (dec_val_s)
  );

  // Synchronizer chain and stability counter next-state
  always_comb begin
    sync_d    = {com, seg};
    smp_d     = sync_q;
    prev_d    = smp_q;
    acc_smp_d = smp_q;
    acc_d     = 1'b0;
    cnt_d     = cnt_q;
    if (smp_q != prev_q) begin
      cnt_d = CNT_ZERO;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_ONE;
      // Registered accept is high in exactly the cycle cnt sits at CNT_ACC
      acc_d = (cnt_q == CNT_PRE) ? 1'b1 : 1'b0;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Phase classification; a LO/HI sample with an undecodable seg is illegal
  always_comb begin
    phase_s = PH_ILLEGAL;
    case (acc_com_s)
      COM_LO: begin
        if (dec_hit_s) begin
          phase_s = PH_LO;
        end else begin
          phase_s = PH_ILLEGAL;
        end
      end
      COM_HI: begin
        if (dec_hit_s) begin
          phase_s = PH_HI;
        end else begin
          phase_s = PH_ILLEGAL;
        end
      end
      COM_BLANK: phase_s = PH_BLANK;
      default:   phase_s = PH_ILLEGAL;
    endcase
  end

  // Pairing FSM next-state and output register next-values
  always_comb begin
    state_d      = state_q;
    lo_tmp_d     = lo_tmp_q;
    digit_lo_d   = digit_lo_q;
    digit_hi_d   = digit_hi_q;
    pair_valid_d = pair_valid_q;
    update_d     = 1'b0;
    err_d        = 1'b0;
    err_count_d  = err_count_q;
    if (acc_q) begin
      case (phase_s)
        PH_LO: begin
          // Newest LSD always wins, whether or not one was pending
          lo_tmp_d = dec_val_s;
          state_d  = HAVE_LO;
        end
        PH_HI: begin
          if (state_q == HAVE_LO) begin
            digit_lo_d   = lo_tmp_q;
            digit_hi_d   = dec_val_s;
            update_d     = 1'b1;
            pair_valid_d = 1'b1;
            state_d      = HUNT;
          end else begin
            // Orphan MSD: discarded silently
            state_d = HUNT;
          end
        end
        PH_ILLEGAL: begin
          err_d   = 1'b1;
          state_d = HUNT;
          if (err_count_q != 8'hFF) begin
            err_count_d = err_count_q + 8'd1;
          end else begin
            err_count_d = err_count_q;
          end
        end
        PH_BLANK: state_d = state_q;
        default:  state_d = HUNT;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State register for the whole block
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q       <= {SMP_W{1'b0}};
      smp_q        <= {SMP_W{1'b0}};
      prev_q       <= {SMP_W{1'b0}};
      cnt_q        <= CNT_ZERO;
      acc_q        <= 1'b0;
      acc_smp_q    <= {SMP_W{1'b0}};
      state_q      <= HUNT;
      lo_tmp_q     <= 4'h0;
      digit_lo_q   <= 4'h0;
      digit_hi_q   <= 4'h0;
      pair_valid_q <= 1'b0;
      update_q     <= 1'b0;
      err_q        <= 1'b0;
      err_count_q  <= 8'h00;
    end else begin
      sync_q       <= sync_d;
      smp_q        <= smp_d;
      prev_q       <= prev_d;
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      acc_smp_q    <= acc_smp_d;
      state_q      <= state_d;
      lo_tmp_q     <= lo_tmp_d;
      digit_lo_q   <= digit_lo_d;
      digit_hi_q   <= digit_hi_d;
      pair_valid_q <= pair_valid_d;
      update_q     <= update_d;
      err_q        <= err_d;
      err_count_q  <= err_count_d;
    end
  end

  assign digit_lo   = digit_lo_q;
  assign digit_hi   = digit_hi_q;
  assign pair_valid = pair_valid_q;
  assign update     = update_q;
  assign err        = err_q;
  assign err_count  = err_count_q;

endmodule

// File: tb/tb_seg_scan_rx.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_rx
// Directed self-checking bench for seg_scan_rx (STABLE_CYCLES=4).
// -----------------------------------------------------------------------------
module tb_seg_scan_rx;

  logic       clock;
  logic       reset;
  logic [3:0] com;
  logic [6:0] seg;
  logic [3:0] digit_lo;
  logic [3:0] digit_hi;
  logic       pair_valid;
  logic       update;
  logic       err;
  logic [7:0] err_count;

  int tests_run;
  int tests_failed;

  // Pulse monitors
  int upd_seen;
  int err_seen;
  int both_seen;
  int pair_bad;
  logic [3:0] exp_lo_r;
  logic [3:0] exp_hi_r;

  seg_scan_rx #(
    .STABLE_CYCLES (4),
    .CNT_W         (3)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .com        (com),
    .seg        (seg),
    .digit_lo   (digit_lo),
    .digit_hi   (digit_hi),
    .pair_valid (pair_valid),
    .update     (update),
    .err        (err),
    .err_count  (err_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Count pulses away from the active edge and check every update pair
  always @(negedge clock) begin
    if (update) begin
      upd_seen = upd_seen + 1;
      if (digit_lo != exp_lo_r || digit_hi != exp_hi_r) pair_bad = pair_bad + 1;
    end
    if (err) err_seen = err_seen + 1;
    if (update && err) both_seen = both_seen + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run = tests_run + 1;
    if (obs !== exp) begin
      tests_failed = tests_failed + 1;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one pattern (called at posedge+1) and hold it for n clocks
  task automatic phase(input logic [3:0] c, input logic [6:0] s, input int n);
    com = c;
    seg = s;
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    com   = 4'b0000;
    seg   = 7'h00;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  int u0, e0, hit_k, hits;

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    upd_seen     = 0;
    err_seen     = 0;
    both_seen    = 0;
    pair_bad     = 0;
    exp_lo_r     = 4'h0;
    exp_hi_r     = 4'h0;
    reset        = 1'b1;
    com          = 4'b0000;
    seg          = 7'h00;
    @(posedge clock);
    #1;
    do_reset();

    // Reset state
    chk("rst_lo",   {28'd0, digit_lo},  32'd0);
    chk("rst_hi",   {28'd0, digit_hi},  32'd0);
    chk("rst_pv",   {31'd0, pair_valid}, 32'd0);
    chk("rst_upd",  {31'd0, update},     32'd0);
    chk("rst_err",  {31'd0, err},        32'd0);
    chk("rst_ecnt", {24'd0, err_count},  32'd0);

    // Test 1: LO=3 then HI=5, update exactly at edge 7 after the HI pattern
    exp_lo_r = 4'h3;
    exp_hi_r = 4'h5;
    phase(4'b1000, 7'h4F, 10);
    com   = 4'b0100;
    seg   = 7'h6D;
    hit_k = 0;
    hits  = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clock);
      #1;
      if (update) begin
        hits  = hits + 1;
        hit_k = k;
      end
    end
    chk("t1_nupd", hits, 32'd1);
    chk("t1_lat",  hit_k, 32'd7);
    chk("t1_lo",   {28'd0, digit_lo}, 32'h3);
    chk("t1_hi",   {28'd0, digit_hi}, 32'h5);
    chk("t1_pv",   {31'd0, pair_valid}, 32'd1);

    // Test 2: four frames of A/F at 8 clocks per phase
    exp_lo_r = 4'hA;
    exp_hi_r = 4'hF;
    u0 = upd_seen;
    for (int f = 0; f < 4; f++) begin
      phase(4'b1000, 7'h77, 8);
      phase(4'b0100, 7'h71, 8);
    end
    chk("t2_nupd", upd_seen - u0, 32'd4);
    chk("t2_ecnt", {24'd0, err_count}, 32'd0);
    chk("t2_lo",   {28'd0, digit_lo}, 32'hA);
    chk("t2_hi",   {28'd0, digit_hi}, 32'hF);

    // Test 3a: short com=1100 glitch between phases is ignored
    u0 = upd_seen;
    e0 = err_seen;
    phase(4'b1000, 7'h77, 8);
    phase(4'b1100, 7'h77, 2);
    phase(4'b0100, 7'h71, 8);
    chk("t3_glitch_err", err_seen - e0, 32'd0);
    chk("t3_glitch_upd", upd_seen - u0, 32'd1);

    // Test 3b: held illegal com aborts a pending LSD
    u0 = upd_seen;
    e0 = err_seen;
    phase(4'b1000, 7'h3F, 8);
    phase(4'b1100, 7'h3F, 8);
    phase(4'b0100, 7'h06, 10);
    chk("t3_ill_err",  err_seen - e0, 32'd1);
    chk("t3_ill_ecnt", {24'd0, err_count}, 32'd1);
    chk("t3_hunt_upd", upd_seen - u0, 32'd0);
    chk("t3_lo_keep",  {28'd0, digit_lo}, 32'hA);
    chk("t3_hi_keep",  {28'd0, digit_hi}, 32'hF);

    // Test 4: undecodable HI seg, then a 1/1 pair
    e0 = err_seen;
    phase(4'b1000, 7'h7F, 8);
    phase(4'b0100, 7'h00, 8);
    phase(4'b0000, 7'h00, 8);
    chk("t4_seg_err",  err_seen - e0, 32'd1);
    chk("t4_ecnt",     {24'd0, err_count}, 32'd2);
    exp_lo_r = 4'h1;
    exp_hi_r = 4'h1;
    u0 = upd_seen;
    phase(4'b1000, 7'h06, 8);
    phase(4'b0100, 7'h06, 10);
    chk("t4_nupd", upd_seen - u0, 32'd1);
    chk("t4_lo",   {28'd0, digit_lo}, 32'h1);
    chk("t4_hi",   {28'd0, digit_hi}, 32'h1);

    // Test 5a: newest LSD wins
    exp_lo_r = 4'h1;
    exp_hi_r = 4'h2;
    u0 = upd_seen;
    phase(4'b1000, 7'h3F, 8);
    phase(4'b1000, 7'h06, 8);
    phase(4'b0100, 7'h5B, 10);
    chk("t5_nupd", upd_seen - u0, 32'd1);
    chk("t5_lo",   {28'd0, digit_lo}, 32'h1);
    chk("t5_hi",   {28'd0, digit_hi}, 32'h2);

    // Test 5b: reset discards the pending LSD
    phase(4'b1000, 7'h3F, 10);
    do_reset();
    u0 = upd_seen;
    phase(4'b0100, 7'h4F, 12);
    chk("t5_rst_upd", upd_seen - u0, 32'd0);
    chk("t5_rst_pv",  {31'd0, pair_valid}, 32'd0);
    chk("t5_rst_lo",  {28'd0, digit_lo}, 32'd0);

    // Test 6: 300 illegal phases saturate err_count
    e0 = err_seen;
    for (int i = 0; i < 150; i++) begin
      phase(4'b1100, 7'h00, 6);
      phase(4'b0011, 7'h00, 6);
    end
    phase(4'b0000, 7'h00, 10);
    chk("t6_nerr", err_seen - e0, 32'd300);
    chk("t6_sat",  {24'd0, err_count}, 32'd255);
    do_reset();
    chk("t6_rst_ecnt", {24'd0, err_count}, 32'd0);
    chk("t6_rst_pv",   {31'd0, pair_valid}, 32'd0);
    chk("t6_rst_hi",   {28'd0, digit_hi}, 32'd0);
    chk("t6_rst_err",  {31'd0, err}, 32'd0);

    // Global properties over the whole run
    chk("pair_content", pair_bad, 32'd0);
    chk("upd_err_excl", both_seen, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
